maq_mh: RTL and testbench

- Downstream stage of the seconds counter in the digital clock.
- Consumes the one-cycle "increment minute" pulse and keeps BCD minutes (00-59) and hours (00-23).
- Includes a button-driven time-set FSM (run / set hour / set minute).
- Drives the display decoders and issues an end-of-day pulse.

---
 rtl/maq_mh.sv | 139 +++++++++++++
 tb/tb_maq_mh.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maq_mh.sv
// Minutes/hours stage of the digital clock: BCD time, run/set FSM, day pulse.
// Optional 12-hour display selected with `define MAQMH_12H_EN.
module maq_mh #(
    parameter int unsigned INICIO_HORA = 0,
    parameter int unsigned INICIO_MIN  = 0
) (
    input  logic       maqmh_clock,
    input  logic       maqmh_reset,
    input  logic       maqmh_incrementaminuto,
    input  logic       maqmh_modo,
    input  logic       maqmh_ajuste,
    output logic [3:0] maqmh_min_lsd,
    output logic [2:0] maqmh_min_msd,
    output logic [3:0] maqmh_hora_lsd,
    output logic [1:0] maqmh_hora_msd,
    output logic       maqmh_ajustando_hora,
    output logic       maqmh_ajustando_min,
    output logic       maqmh_zerasegundos,
    output logic       maqmh_incrementadia,
    output logic       maqmh_pm
);

    typedef enum logic [1:0] {RUN, SET_H, SET_M} state_t;

    localparam logic [3:0] MIN_LSD_RST  = 4'(INICIO_MIN % 10);
    localparam logic [2:0] MIN_MSD_RST  = 3'(INICIO_MIN / 10);
    localparam logic [3:0] HORA_LSD_RST = 4'(INICIO_HORA % 10);
    localparam logic [1:0] HORA_MSD_RST = 2'(INICIO_HORA / 10);

    state_t     state_q;
    logic       modo_prev_q, ajuste_prev_q;
    logic [3:0] min_lsd_q, min_lsd_d;
    logic [2:0] min_msd_q, min_msd_d;
    logic [3:0] hora_lsd_q, hora_lsd_d;
    logic [1:0] hora_msd_q, hora_msd_d;
    logic       zera_q;

    logic modo_edge, ajuste_edge;
    logic run_inc, set_h_inc, set_m_inc;
    logic min_wrap, hora_wrap;

    always_comb begin
        modo_edge   = maqmh_modo & ~modo_prev_q;
        ajuste_edge = maqmh_ajuste & ~ajuste_prev_q;
        run_inc     = (state_q == RUN) & maqmh_incrementaminuto;
        // a modo edge always wins over a coincident ajuste edge
        set_h_inc   = (state_q == SET_H) & ajuste_edge & ~modo_edge;
        set_m_inc   = (state_q == SET_M) & ajuste_edge & ~modo_edge;
        min_wrap    = (min_msd_q == 3'd5) & (min_lsd_q == 4'd9);
        hora_wrap   = (hora_msd_q == 2'd2) & (hora_lsd_q == 4'd3);

        min_lsd_d  = min_lsd_q;
        min_msd_d  = min_msd_q;
        hora_lsd_d = hora_lsd_q;
        hora_msd_d = hora_msd_q;

        if (run_inc || set_m_inc) begin
            if (min_lsd_q == 4'd9) begin
                min_lsd_d = '0;
                min_msd_d = (min_msd_q == 3'd5) ? '0 : min_msd_q + 3'd1;
            end else begin
                min_lsd_d = min_lsd_q + 4'd1;
            end
        end

        if ((run_inc && min_wrap) || set_h_inc) begin
            if (hora_wrap) begin
                hora_lsd_d = '0;
                hora_msd_d = '0;
            end else if (hora_lsd_q == 4'd9) begin
                hora_lsd_d = '0;
                hora_msd_d = hora_msd_q + 2'd1;
            end else begin
                hora_lsd_d = hora_lsd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge maqmh_clock or negedge maqmh_reset) begin
        if (!maqmh_reset) begin
            state_q       <= RUN;
            modo_prev_q   <= 1'b0;
            ajuste_prev_q <= 1'b0;
            min_lsd_q     <= MIN_LSD_RST;
            min_msd_q     <= MIN_MSD_RST;
            hora_lsd_q    <= HORA_LSD_RST;
            hora_msd_q    <= HORA_MSD_RST;
            zera_q        <= 1'b0;
        end else begin
            modo_prev_q   <= maqmh_modo;
            ajuste_prev_q <= maqmh_ajuste;
            min_lsd_q     <= min_lsd_d;
            min_msd_q     <= min_msd_d;
            hora_lsd_q    <= hora_lsd_d;
            hora_msd_q    <= hora_msd_d;
            zera_q        <= 1'b0;
            if (modo_edge) begin
                case (state_q)
                    RUN:     state_q <= SET_H;
                    SET_H:   state_q <= SET_M;
                    SET_M: begin
                        state_q <= RUN;
                        zera_q  <= 1'b1;
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign maqmh_min_lsd        = min_lsd_q;
    assign maqmh_min_msd        = min_msd_q;
    assign maqmh_ajustando_hora = (state_q == SET_H);
    assign maqmh_ajustando_min  = (state_q == SET_M);
    assign maqmh_zerasegundos   = zera_q;
    assign maqmh_incrementadia  = run_inc & min_wrap & hora_wrap;

`ifdef MAQMH_12H_EN
    logic [4:0] hora_bin, hora_12;

    always_comb begin
        hora_bin = 5'(hora_msd_q) * 5'd10 + 5'(hora_lsd_q);
        if (hora_bin == 5'd0)
            hora_12 = 5'd12;
        else if (hora_bin > 5'd12)
            hora_12 = hora_bin - 5'd12;
        else
            hora_12 = hora_bin;
        maqmh_hora_msd = (hora_12 >= 5'd10) ? 2'd1 : 2'd0;
        maqmh_hora_lsd = (hora_12 >= 5'd10) ? 4'(hora_12 - 5'd10) : 4'(hora_12);
        maqmh_pm       = (hora_bin >= 5'd12);
    end
`else
    assign maqmh_hora_lsd = hora_lsd_q;
    assign maqmh_hora_msd = hora_msd_q;
    assign maqmh_pm       = 1'b0;
`endif

endmodule

// File: tb/tb_maq_mh.sv
// Bench for maq_mh: time-in-minutes reference model, per-cycle compare, directed and random stimulus.
module tb_maq_mh;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc = 1'b0, modo = 1'b0, aj = 1'b0;
    logic [3:0] min_lsd, hora_lsd;
    logic [2:0] min_msd;
    logic [1:0] hora_msd;
    logic       aj_h, aj_m, zera, dia, pm;

    maq_mh #(.INICIO_HORA(0), .INICIO_MIN(0)) dut (
        .maqmh_clock(clk),
        .maqmh_reset(rst_n),
        .maqmh_incrementaminuto(inc),
        .maqmh_modo(modo),
        .maqmh_ajuste(aj),
        .maqmh_min_lsd(min_lsd),
        .maqmh_min_msd(min_msd),
        .maqmh_hora_lsd(hora_lsd),
        .maqmh_hora_msd(hora_msd),
        .maqmh_ajustando_hora(aj_h),
        .maqmh_ajustando_min(aj_m),
        .maqmh_zerasegundos(zera),
        .maqmh_incrementadia(dia),
        .maqmh_pm(pm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // reference model: mode 0=run 1=set hour 2=set minute
    int m_mode = 0, m_h = 0, m_m = 0;
    bit m_pmodo = 0, m_paj = 0, m_zera = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int disp_hour(input int h);
`ifdef MAQMH_12H_EN
        if (h % 12 == 0) return 12;
        return h % 12;
`else
        return h;
`endif
    endfunction

    function automatic int exp_pm(input int h);
`ifdef MAQMH_12H_EN
        return (h >= 12) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_h = 0; m_m = 0;
            m_pmodo = 0; m_paj = 0; m_zera = 0;
        end else begin
            bit me, ae;
            int t;
            me = modo && !m_pmodo;
            ae = aj && !m_paj;
            m_zera = 0;
            if (m_mode == 0 && inc) begin
                t = (m_h * 60 + m_m + 1) % 1440;
                m_h = t / 60;
                m_m = t % 60;
            end
            if (me) begin
                if (m_mode == 2) m_zera = 1;
                m_mode = (m_mode + 1) % 3;
            end else if (ae) begin
                if (m_mode == 1) m_h = (m_h + 1) % 24;
                if (m_mode == 2) m_m = (m_m + 1) % 60;
            end
            m_pmodo = modo;
            m_paj = aj;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("min_lsd", int'(min_lsd), m_m % 10);
            chk("min_msd", int'(min_msd), m_m / 10);
            chk("hora", int'(hora_msd) * 10 + int'(hora_lsd), disp_hour(m_h));
            chk("hora_lsd_range", int'(hora_lsd <= 4'd9), 1);
            chk("pm", int'(pm), exp_pm(m_h));
            chk("ajustando_hora", int'(aj_h), int'(m_mode == 1));
            chk("ajustando_min", int'(aj_m), int'(m_mode == 2));
            chk("zerasegundos", int'(zera), int'(m_zera));
            chk("incrementadia", int'(dia),
                int'(inc && m_mode == 0 && m_h == 23 && m_m == 59));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input bit pm_, input bit pa);
        modo = pm_; aj = pa;
        step();
        modo = 0; aj = 0;
        step();
    endtask

    task automatic chk_time(input string name, input int h, input int m);
        chk({name, "_hora"}, int'(hora_msd) * 10 + int'(hora_lsd), disp_hour(h));
        chk({name, "_min"}, int'(min_msd) * 10 + int'(min_lsd), m);
    endtask

    task automatic set_time(input int h, input int m);
        int n;
        press(1, 0);
        n = (h - m_h + 24) % 24;
        for (int i = 0; i < n; i++) press(0, 1);
        press(1, 0);
        n = (m - m_m + 60) % 60;
        for (int i = 0; i < n; i++) press(0, 1);
        press(1, 0);
    endtask

    task automatic pulse_inc();
        inc = 1;
        step();
        inc = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_min", int'(min_msd) * 10 + int'(min_lsd), 0);
        chk("reset_hora", int'(hora_msd) * 10 + int'(hora_lsd), disp_hour(0));
        chk("reset_flags", int'({aj_h, aj_m, zera, dia}), 0);
        rst_n = 1;
        step();
        cmp_en = 1;

        // reset asserted while in SET_M at 07:33
        press(1, 0);
        for (int i = 0; i < 7; i++) press(0, 1);
        press(1, 0);
        for (int i = 0; i < 33; i++) press(0, 1);
        chk_time("set_0733", 7, 33);
        chk("in_set_m", int'(aj_m), 1);
        rst_n = 0;
        #1;
        chk_time("mid_reset", 0, 0);
        chk("mid_reset_flags", int'({aj_h, aj_m, zera}), 0);
        #1 rst_n = 1;
        step();
        chk("no_zera_after_reset", int'(zera), 0);

        // rollovers in RUN
        set_time(23, 59);
        inc = 1;
        #1;
        chk("dia_2359", int'(dia), 1);
        step();
        inc = 0;
        chk_time("roll_0000", 0, 0);
        chk("dia_after", int'(dia), 0);
        set_time(9, 59);
        pulse_inc();
        chk_time("roll_1000", 10, 0);
        set_time(19, 59);
        pulse_inc();
        chk_time("roll_2000", 20, 0);

        // minute set wraps without carry; incrementaminuto frozen
        set_time(12, 58);
        press(1, 0);
        press(1, 0);
        for (int i = 0; i < 3; i++) press(0, 1);
        chk_time("setm_1201", 12, 1);
        inc = 1;
        repeat (3) step();
        inc = 0;
        chk_time("setm_frozen", 12, 1);
        modo = 1;
        step();
        chk("zera_pulse", int'(zera), 1);
        chk("back_run", int'({aj_h, aj_m}), 0);
        modo = 0;
        step();
        chk("zera_one_cycle", int'(zera), 0);

        // hour set wrap, held button, simultaneous edges
        set_time(22, 10);
        press(1, 0);
        press(0, 1);
        press(0, 1);
        chk_time("seth_0010", 0, 10);
        aj = 1;
        repeat (20) step();
        aj = 0;
        step();
        chk_time("held_aj", 1, 10);
        press(1, 1);
        chk("simul_state", int'(aj_m), 1);
        chk_time("simul_time", 1, 10);
        press(1, 0);

        // display format
        set_time(0, 5);
`ifdef MAQMH_12H_EN
        chk("h12_0005", int'({2'b0, hora_msd, hora_lsd}), 8'h12);
        chk("h12_0005_pm", int'(pm), 0);
`else
        chk("h24_0005", int'({2'b0, hora_msd, hora_lsd}), 8'h00);
`endif
        set_time(13, 0);
`ifdef MAQMH_12H_EN
        chk("h12_1300", int'({2'b0, hora_msd, hora_lsd}), 8'h01);
        chk("h12_1300_pm", int'(pm), 1);
`else
        chk("h24_1300", int'({2'b0, hora_msd, hora_lsd}), 8'h13);
        chk("h24_1300_pm", int'(pm), 0);
`endif

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            inc  = ($urandom % 6) == 0;
            modo = ($urandom % 12) == 0;
            aj   = ($urandom % 3) == 0;
            if (($urandom % 1500) == 0) begin
                rst_n = 0;
                #2 rst_n = 1;
            end
            step();
        end
        inc = 0; modo = 0; aj = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
